// File: rtl/hrm_fetch_if.sv
// Opcode/ROM bus between the HRM program sequencer and its neighbours.
// The master side is the sequencer. The slave side is the ROM, the control unit and the datapath.
interface hrm_fetch_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] rom_addr;
  logic            rom_rd;
  logic [7:0]      rom_data;
  logic [3:0]      opcode;
  logic [7:0]      operand;
  logic            instr_valid;
  logic            exec_done;
  logic            branch;
  logic            ijump;
  logic            cond;
  logic [PC_W-1:0] pc;
  logic            halted;

  modport master (
    output rom_addr, rom_rd, opcode, operand, instr_valid, pc, halted,
    input  rom_data, exec_done, branch, ijump, cond
  );

  modport slave (
    input  rom_addr, rom_rd, opcode, operand, instr_valid, pc, halted,
    output rom_data, exec_done, branch, ijump, cond
  );
endinterface

// File: rtl/hrm_fetch.sv
// HRM program sequencer. It fetches an opcode byte and an optional operand byte from a synchronous ROM.
// It issues the instruction with a valid/done handshake and then resolves the next PC.
module hrm_fetch #(
  parameter int         PC_W    = 8,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic      clk,
  input  logic      rst,
  hrm_fetch_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, FETCH_ARG, LATCH_ARG, ISSUE, HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pcReg;
  logic [3:0]      opcodeReg;
  logic [7:0]      operandReg;
  logic            instrValid;
  logic            haltedReg;

  function automatic logic [PC_W-1:0] pcInc(input logic [PC_W-1:0] p);
    return p + PC_W'(1);
  endfunction

  function automatic logic [PC_W-1:0] jumpTarget(input logic [7:0] arg);
    return PC_W'(arg);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pcReg      <= '0;
      opcodeReg  <= '0;
      operandReg <= '0;
      instrValid <= 1'b0;
      haltedReg  <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          opcodeReg <= bus.rom_data[7:4];
          pcReg     <= pcInc(pcReg);
          if (bus.rom_data[7:4] == HALT_OP) begin
            haltedReg <= 1'b1;
            state     <= HALT;
          end else if (bus.rom_data[3]) begin
            state <= FETCH_ARG;
          end else begin
            operandReg <= '0;
            instrValid <= 1'b1;
            state      <= ISSUE;
          end
        end
        FETCH_ARG: state <= LATCH_ARG;
        LATCH_ARG: begin
          operandReg <= bus.rom_data;
          pcReg      <= pcInc(pcReg);
          instrValid <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          // pcReg already points past the instruction, so only a taken jump rewrites it
          if (bus.exec_done) begin
            if (bus.ijump || (bus.branch && bus.cond))
              pcReg <= jumpTarget(operandReg);
            instrValid <= 1'b0;
            state      <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // The read strobe is gated by rst so that no ROM read is issued while the sequencer is held in reset.
  assign bus.rom_rd      = !rst && ((state == FETCH) || (state == FETCH_ARG));
  assign bus.rom_addr    = pcReg;
  assign bus.pc          = pcReg;
  assign bus.opcode      = opcodeReg;
  assign bus.operand     = operandReg;
  assign bus.instr_valid = instrValid;
  assign bus.halted      = haltedReg;

endmodule

// File: tb/tb_hrm_fetch.sv
// Bench for hrm_fetch. It covers directed scenarios plus a randomized program.
// The randomized program is checked against an instruction-level model of the ROM program.
module tb_hrm_fetch;
  logic clk;
  logic rst;
  int   errs;
  int   checks;
  logic [7:0] rom [256];

  hrm_fetch_if #(.PC_W(8)) bus();

  hrm_fetch #(.PC_W(8), .HALT_OP(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic clearInputs();
    bus.exec_done = 1'b0; bus.branch = 1'b0; bus.ijump = 1'b0; bus.cond = 1'b0;
  endtask

  task automatic romFill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Expected outcome of executing the instruction at address p (no halt).
  function automatic void refInstr(input logic [7:0] p, output logic [3:0] op,
                                   output logic [7:0] opr, output logic [7:0] npc, output int lat);
    logic [7:0] b;
    b  = rom[p];
    op = b[7:4];
    if (b[3]) begin opr = rom[8'(p + 1)]; npc = 8'(p + 2); lat = 4; end
    else      begin opr = 8'h00;          npc = 8'(p + 1); lat = 2; end
  endfunction

  // Runs one instruction through fetch and issue, holding it for `hold` cycles before exec_done.
  task automatic runInstr(input int hold, input bit jmp, input bit br, input bit cnd,
                          output logic [7:0] fAddr, output int lat, output logic [3:0] op,
                          output logic [7:0] opr, output logic [7:0] pcIss,
                          output bit okHs, output bit to);
    int w;
    w = 0; okHs = 1'b1; lat = 0;
    while (bus.rom_rd !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    fAddr = bus.rom_addr;
    do begin @(negedge clk); lat++; end
    while (bus.instr_valid !== 1'b1 && bus.halted !== 1'b1 && lat < 20);
    to    = (w >= 20) || (bus.instr_valid !== 1'b1);
    op    = bus.opcode;
    opr   = bus.operand;
    pcIss = bus.pc;
    if (!to) begin
      repeat (hold) begin
        @(negedge clk);
        if (bus.instr_valid !== 1'b1 || bus.opcode !== op || bus.operand !== opr) okHs = 1'b0;
      end
      bus.exec_done = 1'b1; bus.ijump = jmp; bus.branch = br; bus.cond = cnd;
      @(negedge clk);
      if (bus.instr_valid !== 1'b0) okHs = 1'b0;
      clearInputs();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    romFill(8'h00);
    for (int i = 0; i < 2; i++) begin @(negedge clk); bus.exec_done = ~bus.exec_done; end
    checks++; if (bus.rom_rd !== 1'b0) begin errs++; $display("FAIL rst_rom_rd: got %0b want 0", bus.rom_rd); end
    checks++; if (bus.instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %0b want 0", bus.instr_valid); end
    checks++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %0b want 0", bus.halted); end
    checks++; if (bus.pc !== 8'h00) begin errs++; $display("FAIL rst_pc: got %0h want 0", bus.pc); end
    checks++; if (bus.opcode !== 4'h0) begin errs++; $display("FAIL rst_opcode: got %0h want 0", bus.opcode); end
    checks++; if (bus.operand !== 8'h00) begin errs++; $display("FAIL rst_operand: got %0h want 0", bus.operand); end
    bus.exec_done = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.rom_rd !== 1'b1) begin errs++; $display("FAIL rst_first_rd: got %0b want 1", bus.rom_rd); end
    checks++; if (bus.rom_addr !== 8'h00) begin errs++; $display("FAIL rst_first_addr: got %0h want 0", bus.rom_addr); end
  endtask

  task automatic test_straight_line();
    logic [7:0] fa, opr, pci; logic [3:0] op; int lat; bit ok, to;
    romFill(8'h00);
    rom[0] = 8'h10; rom[1] = 8'h38; rom[2] = 8'h05;
    applyReset();
    runInstr(1, 1'b0, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    checks++; if (to !== 1'b0) begin errs++; $display("FAIL sl1_timeout: got %0b want 0", to); end
    checks++; if (fa !== 8'h00) begin errs++; $display("FAIL sl1_addr: got %0h want 0", fa); end
    checks++; if (op !== 4'h1) begin errs++; $display("FAIL sl1_opcode: got %0h want 1", op); end
    checks++; if (opr !== 8'h00) begin errs++; $display("FAIL sl1_operand: got %0h want 0", opr); end
    checks++; if (lat !== 2) begin errs++; $display("FAIL sl1_latency: got %0d want 2", lat); end
    checks++; if (ok !== 1'b1) begin errs++; $display("FAIL sl1_handshake: got %0b want 1", ok); end
    runInstr(1, 1'b0, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    checks++; if (fa !== 8'h01) begin errs++; $display("FAIL sl2_addr: got %0h want 1", fa); end
    checks++; if (op !== 4'h3) begin errs++; $display("FAIL sl2_opcode: got %0h want 3", op); end
    checks++; if (opr !== 8'h05) begin errs++; $display("FAIL sl2_operand: got %0h want 05", opr); end
    checks++; if (lat !== 4) begin errs++; $display("FAIL sl2_latency: got %0d want 4", lat); end
    checks++; if (bus.pc !== 8'h03) begin errs++; $display("FAIL sl_pc_after: got %0h want 3", bus.pc); end
  endtask

  task automatic test_jumps();
    logic [7:0] fa, opr, pci; logic [3:0] op; int lat; bit ok, to;
    romFill(8'h00);
    rom[0] = 8'h88; rom[1] = 8'h40;
    applyReset();
    runInstr(0, 1'b1, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    checks++; if (op !== 4'h8 || opr !== 8'h40) begin errs++; $display("FAIL ij_instr: got %0h/%0h want 8/40", op, opr); end
    checks++; if (ok !== 1'b1) begin errs++; $display("FAIL ij_one_cycle_valid: got %0b want 1", ok); end
    checks++; if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 8'h40) begin errs++; $display("FAIL ij_next_fetch: got rd=%0b addr=%0h want rd=1 addr=40", bus.rom_rd, bus.rom_addr); end
    applyReset();
    runInstr(0, 1'b0, 1'b1, 1'b0, fa, lat, op, opr, pci, ok, to);
    checks++; if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 8'h02) begin errs++; $display("FAIL br_nt_next_fetch: got rd=%0b addr=%0h want rd=1 addr=02", bus.rom_rd, bus.rom_addr); end
    applyReset();
    runInstr(5, 1'b0, 1'b1, 1'b1, fa, lat, op, opr, pci, ok, to);
    checks++; if (ok !== 1'b1) begin errs++; $display("FAIL br_t_stable_hold: got %0b want 1", ok); end
    checks++; if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 8'h40) begin errs++; $display("FAIL br_t_next_fetch: got rd=%0b addr=%0h want rd=1 addr=40", bus.rom_rd, bus.rom_addr); end
  endtask

  task automatic test_wrap();
    logic [7:0] fa, opr, pci; logic [3:0] op; int lat; bit ok, to;
    romFill(8'h00);
    rom[0] = 8'h98; rom[1] = 8'hFE; rom[2] = 8'h98; rom[3] = 8'hFF;
    rom[8'hFE] = 8'h18; rom[8'hFF] = 8'h22;
    applyReset();
    runInstr(0, 1'b1, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    runInstr(1, 1'b0, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    checks++; if (fa !== 8'hFE) begin errs++; $display("FAIL wrap_fetch_addr: got %0h want fe", fa); end
    checks++; if (op !== 4'h1 || opr !== 8'h22) begin errs++; $display("FAIL wrap_instr: got %0h/%0h want 1/22", op, opr); end
    checks++; if (pci !== 8'h00) begin errs++; $display("FAIL wrap_pc_issue: got %0h want 0", pci); end
    checks++; if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 8'h00) begin errs++; $display("FAIL wrap_next_fetch: got rd=%0b addr=%0h want rd=1 addr=00", bus.rom_rd, bus.rom_addr); end
    runInstr(0, 1'b0, 1'b1, 1'b0, fa, lat, op, opr, pci, ok, to);
    runInstr(0, 1'b1, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    runInstr(0, 1'b0, 1'b0, 1'b0, fa, lat, op, opr, pci, ok, to);
    checks++; if (fa !== 8'hFF || op !== 4'h2 || opr !== 8'h00) begin errs++; $display("FAIL wrap_ff_instr: got addr=%0h op=%0h opr=%0h want ff/2/00", fa, op, opr); end
    checks++; if (pci !== 8'h00) begin errs++; $display("FAIL wrap_inc_ff: got %0h want 0", pci); end
  endtask

  task automatic test_halt_and_reset();
    bit bad;
    romFill(8'h00);
    rom[0] = 8'hF0;
    applyReset();
    repeat (2) @(negedge clk);
    checks++; if (bus.halted !== 1'b1) begin errs++; $display("FAIL halt_rise: got %0b want 1", bus.halted); end
    checks++; if (bus.pc !== 8'h01) begin errs++; $display("FAIL halt_pc: got %0h want 1", bus.pc); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.exec_done = i[0];
      @(negedge clk);
      if (bus.rom_rd !== 1'b0 || bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 8'h01) bad = 1'b1;
    end
    bus.exec_done = 1'b0;
    checks++; if (bad !== 1'b0) begin errs++; $display("FAIL halt_hold: got bad=%0b want 0", bad); end
    rom[0] = 8'h18; rom[1] = 8'h77;
    applyReset();
    repeat (4) @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 8'h02) begin errs++; $display("FAIL rst_mid_issue_pre: got valid=%0b pc=%0h want 1/02", bus.instr_valid, bus.pc); end
    rst = 1'b1; bus.exec_done = 1'b1; bus.ijump = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 8'h00 || bus.rom_rd !== 1'b0) begin errs++; $display("FAIL rst_mid_issue: got valid=%0b pc=%0h rd=%0b want 0/00/0", bus.instr_valid, bus.pc, bus.rom_rd); end
    rst = 1'b0;
    clearInputs();
    #1;
    checks++; if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 8'h00) begin errs++; $display("FAIL rst_mid_restart: got rd=%0b addr=%0h want 1/00", bus.rom_rd, bus.rom_addr); end
  endtask

  task automatic test_random_program();
    logic [7:0] fa, opr, pci, p, eOpr, eNpc, b; logic [3:0] op, eOp; int lat, eLat; bit ok, to, jmp, br, cnd;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF) b[7:4] = 4'hE;
      rom[i] = b;
    end
    applyReset();
    p = 8'h00;
    for (int n = 0; n < 40; n++) begin
      refInstr(p, eOp, eOpr, eNpc, eLat);
      jmp = ($urandom_range(0, 3) == 0);
      br  = 1'($urandom);
      cnd = 1'($urandom);
      runInstr($urandom_range(0, 3), jmp, br, cnd, fa, lat, op, opr, pci, ok, to);
      checks++; if (to !== 1'b0 || fa !== p) begin errs++; $display("FAIL rnd%0d_fetch: got addr=%0h to=%0b want %0h/0", n, fa, to, p); end
      checks++; if (op !== eOp || opr !== eOpr) begin errs++; $display("FAIL rnd%0d_instr: got %0h/%0h want %0h/%0h", n, op, opr, eOp, eOpr); end
      checks++; if (pci !== eNpc) begin errs++; $display("FAIL rnd%0d_pc: got %0h want %0h", n, pci, eNpc); end
      checks++; if (lat !== eLat || ok !== 1'b1) begin errs++; $display("FAIL rnd%0d_timing: got lat=%0d hs=%0b want %0d/1", n, lat, ok, eLat); end
      p = (jmp || (br && cnd)) ? eOpr : eNpc;
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_straight_line();
    test_jumps();
    test_wrap();
    test_halt_and_reset();
    test_random_program();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hrm_fetch.md
# hrm_fetch

Program sequencer for the HRM CPU: owns the program counter, reads instruction bytes from the synchronous program ROM, and assembles them into an opcode plus optional operand. It presents the result to `controlUnit` and the datapath with a valid/done handshake. It consumes the `branch`/`ijump` decisions and branch condition, and computes the next PC. It is the producer side of the opcode interface that `controlUnit` decodes.

## Interface
Parameters:
- `PC_W`, 8: program counter / ROM address width.
- `HALT_OP`, 4'hF: opcode that stops the sequencer.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_addr`  out  PC_W  program ROM address.
- `rom_rd`  out  1  ROM read strobe; data returned on `rom_data` the following cycle.
- `rom_data`  in  8  ROM read data; bits [7:4] are the opcode, bit [3] is the has-operand flag, bits [2:0] are ignored.
- `opcode`  out  4  current instruction opcode, to `controlUnit`.
- `operand`  out  8  operand byte (address / jump target); 0 when the instruction has none.
- `instr_valid`  out  1  opcode/operand stable and ready for execution.
- `exec_done`  in  1  datapath finished the current instruction.
- `branch`  in  1  from `controlUnit`: conditional jump.
- `ijump`  in  1  from `controlUnit`: unconditional jump.
- `cond`  in  1  branch condition from the datapath (zero/negative test already selected).
- `pc`  out  PC_W  current PC, for debug.
- `halted`  out  1  the HALT opcode has been reached.

## Operation
States:
- **FETCH**
  - `rom_addr = pc`, `rom_rd = 1`.
  - Next state: DECODE.
- **DECODE**
  - Latch `rom_data[7:4]` into `opcode`; set `pc <= pc+1`.
  - If the opcode is HALT_OP, go to HALT (operand flag ignored).
  - Else if `rom_data[3]`, go to FETCH_ARG.
  - Else set `operand <= 0` and go to ISSUE.
- **FETCH_ARG**
  - `rom_addr = pc`, `rom_rd = 1`.
  - Next state: LATCH_ARG.
- **LATCH_ARG**
  - Set `operand <= rom_data` and `pc <= pc+1`.
  - Next state: ISSUE.
- **ISSUE**
  - `instr_valid = 1`; `opcode` and `operand` held stable.
  - Stay in ISSUE until `exec_done = 1`.
  - On `exec_done`:
    - if `ijump`, or `branch` with `cond`, then `pc <= operand[PC_W-1:0]`;
    - otherwise `pc` is unchanged (it already points at the next instruction).
    - Next state: FETCH.
- **HALT**
  - `halted = 1`, `instr_valid = 0`, `rom_rd = 0`.
  - Only `rst` leaves this state.

Rules:
- `branch` and `ijump` are sampled only in the cycle where `instr_valid` and `exec_done` are both high.
- `ijump` takes priority; `cond` is a don't-care when `ijump = 1`.
- `exec_done` outside ISSUE is ignored.
- `rom_rd` is high only in FETCH and FETCH_ARG.
- PC arithmetic is modulo 2^PC_W:
  - an increment from all-ones wraps to 0;
  - an operand fetched at all-ones is read from address all-ones, and the next opcode comes from 0.

## Timing
- Reset values: state FETCH, `pc = 0`, `opcode = 0`, `operand = 0`, `instr_valid = 0`, `halted = 0`, `rom_rd = 0` (combinational from state; the first read is in the cycle after `rst` deasserts).
- `rst` asserted in any state, including mid-ISSUE and HALT, aborts within that edge. No pending PC update survives it.
- Latency from entering FETCH to `instr_valid` rising:
  - no-operand instruction: 2 cycles;
  - instruction with operand: 4 cycles.
- `exec_done` in the first ISSUE cycle is allowed. The instruction is then valid for exactly 1 cycle, and the next FETCH is the following cycle.
- Minimum loop period: 3 cycles (no operand) or 5 cycles (with operand), counted from FETCH to FETCH.
- `halted` rises the cycle after DECODE sees HALT_OP. `pc` at that point is the HALT address + 1.

## Test plan
- **Reset:** hold `rst` 2 cycles with `exec_done` toggling -> all outputs at reset values. The first `rom_rd` appears with `rom_addr = 0` in the cycle after release.
- **Straight-line:** ROM[0]=0x10, ROM[1]=0x38, ROM[2]=0x05; `exec_done` one cycle after each `instr_valid`.
  - First instruction: `opcode = 1`, `operand = 0`.
  - Second instruction: `opcode = 3`, `operand = 0x05`; `instr_valid` rises 4 cycles after its FETCH.
  - `pc = 3` afterwards.
- **Jumps** (first two with `exec_done` in the first ISSUE cycle):
  - ROM[0]=0x88, ROM[1]=0x40, `ijump = 1` -> the next `rom_addr` is 0x40.
  - Same program with `branch = 1`, `cond = 0` -> the next fetch is at 2.
  - Same program with `branch = 1`, `cond = 1`, `exec_done` held low 5 cycles -> `opcode`/`operand` stable throughout, then the next fetch is at 0x40.
- **Wrap:** PC_W=8, ROM[0xFE]=0x18, ROM[0xFF]=0x22 -> `operand = 0x22`, then the next opcode fetch is at 0x00.
- **Halt and reset mid-operation:** ROM[0]=0xF0 -> `halted = 1` and `rom_rd` stays 0 for 20 cycles; `exec_done` pulses are ignored. Then assert `rst` during an ISSUE of a later program -> `instr_valid` drops the next edge and fetch restarts at 0.
